// File: rtl/seven_segment_scan.sv
// Purpose : multiplexed seven-segment controller; captures NUM_DIGITS 4-bit codes on
//           load and scans them one digit per REFRESH_DIV-cycle slot onto shared segments.
// Latency : outputs are registered and update only on prescaler tick edges; a load is
//           displayed from the first tick strictly after the load edge.
// Backpressure: none; load is accepted every cycle it is asserted.
//
// Ports:
//   clk        single clock, rising edge
//   reset_a    asynchronous active-low reset; clears all state and outputs
//   digits_in  packed codes, bits [4k+3:4k] = digit k (digit 0 least significant)
//   load       capture digits_in into the shadow register on this edge
//   blank_lz   1 = suppress leading zeros (sampled at the tick edge)
//   seg_a..g   active-high segment drives, registered
//   digit_en   one-hot active-high digit select, registered
//
// Configuration: define SEVEN_SEG_HEX_EN to decode codes 10-15 as hex glyphs A b C d E F;
//                otherwise those codes display a dash (segment g only).

module seven_segment_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                    clk,
    input  logic                    reset_a,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    seg_a,
    output logic                    seg_b,
    output logic                    seg_c,
    output logic                    seg_d,
    output logic                    seg_e,
    output logic                    seg_f,
    output logic                    seg_g,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           r_presc;
    logic [PTR_W-1:0]        r_ptr;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [6:0]              r_seg;      // {g,f,e,d,c,b,a}
    logic [NUM_DIGITS-1:0]   r_digit_en;

    logic                    w_tick;
    logic [3:0]              w_code;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_nz;
    logic [NUM_DIGITS-1:0]   w_nz_at_or_above;
    logic                    w_blank;
    logic [PTR_W-1:0]        w_ptr_nxt;

    assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_code = r_shadow[4*r_ptr +: 4];

    // Per-digit non-zero flags; a code >= 10 counts as non-zero.
    always_comb begin
        w_nz = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_nz[k] = (r_shadow[4*k +: 4] != 4'd0);
        end
    end

    // Digit ptr is a leading zero iff no digit at or above it is non-zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    assign w_nz_at_or_above = w_nz >> r_ptr;
    assign w_blank = blank_lz && (r_ptr != '0) && (w_nz_at_or_above == '0);

    assign w_ptr_nxt = (r_ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : r_ptr + 1'b1;

    // Glyph table, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        w_glyph = 7'h00;
        case (w_code)
            4'd0:    w_glyph = 7'h3F;
            4'd1:    w_glyph = 7'h06;
            4'd2:    w_glyph = 7'h5B;
            4'd3:    w_glyph = 7'h4F;
            4'd4:    w_glyph = 7'h66;
            4'd5:    w_glyph = 7'h6D;
            4'd6:    w_glyph = 7'h7D;
            4'd7:    w_glyph = 7'h07;
            4'd8:    w_glyph = 7'h7F;
            4'd9:    w_glyph = 7'h6F;
`ifdef SEVEN_SEG_HEX_EN
            4'd10:   w_glyph = 7'h77;
            4'd11:   w_glyph = 7'h7C;
            4'd12:   w_glyph = 7'h39;
            4'd13:   w_glyph = 7'h5E;
            4'd14:   w_glyph = 7'h79;
            default: w_glyph = 7'h71;
`else
            default: w_glyph = 7'h40;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            r_presc    <= '0;
            r_ptr      <= '0;
            r_shadow   <= '0;
            r_seg      <= '0;
            r_digit_en <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            // Shadow updates in parallel with the tick, so a same-edge tick sees the old value.
            if (load) begin
                r_shadow <= digits_in;
            end
            if (w_tick) begin
                r_digit_en <= NUM_DIGITS'(1) << r_ptr;
                r_seg      <= w_blank ? 7'h00 : w_glyph;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    assign seg_a    = r_seg[0];
    assign seg_b    = r_seg[1];
    assign seg_c    = r_seg[2];
    assign seg_d    = r_seg[3];
    assign seg_e    = r_seg[4];
    assign seg_f    = r_seg[5];
    assign seg_g    = r_seg[6];
    assign digit_en = r_digit_en;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with NUM_DIGITS=4, REFRESH_DIV=4.
// Segment expectations are written as {g,f,e,d,c,b,a} constants derived from the glyph list.
module tb_seven_segment_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    // Hand-derived glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] G0    = 7'b0111111; // abcdef
    localparam logic [6:0] G1    = 7'b0000110; // bc
    localparam logic [6:0] G2    = 7'b1011011; // abdeg
    localparam logic [6:0] G3    = 7'b1001111; // abcdg
    localparam logic [6:0] G4    = 7'b1100110; // bcfg
    localparam logic [6:0] G5    = 7'b1101101; // acdfg
    localparam logic [6:0] G9    = 7'b1101111; // abcdfg
    localparam logic [6:0] GOFF  = 7'b0000000;
`ifdef SEVEN_SEG_HEX_EN
    localparam logic [6:0] GA    = 7'b1110111; // abcefg
    localparam logic [6:0] GB    = 7'b1111100; // cdefg
    localparam logic [6:0] GC    = 7'b0111001; // adef
    localparam logic [6:0] GF    = 7'b1110001; // aefg
`else
    localparam logic [6:0] GA    = 7'b1000000; // dash
    localparam logic [6:0] GB    = 7'b1000000;
    localparam logic [6:0] GC    = 7'b1000000;
    localparam logic [6:0] GF    = 7'b1000000;
`endif

    logic          clk;
    logic          reset_a;
    logic [4*ND-1:0] digits_in;
    logic          load;
    logic          blank_lz;
    logic          seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [ND-1:0] digit_en;

    int n_cmp;
    int n_err;

    seven_segment_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .digits_in (digits_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .seg_c     (seg_c),
        .seg_d     (seg_d),
        .seg_e     (seg_e),
        .seg_f     (seg_f),
        .seg_g     (seg_g),
        .digit_en  (digit_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [ND-1:0] exp_en, input logic [6:0] exp_seg);
        check({tag, ".en"},  {4'b0, digit_en}, {4'b0, exp_en});
        check({tag, ".seg"}, {1'b0, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a}, {1'b0, exp_seg});
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_a   = 1'b0;
        load      = 1'b0;
        blank_lz  = 1'b0;
        digits_in = '0;

        // Reset state
        edges(3);
        check_out("reset", 4'b0000, GOFF);

        // Release, load 1234 on edge 1; first tick on edge 4
        reset_a   = 1'b1;
        digits_in = 16'h1234;
        load      = 1'b1;
        edges(1);
        load      = 1'b0;
        edges(2);
        check_out("pre_first_tick", 4'b0000, GOFF);
        edges(1);
        check_out("scan_d0", 4'b0001, G4);
        edges(3);
        check_out("scan_hold", 4'b0001, G4);
        edges(1);
        check_out("scan_d1", 4'b0010, G3);
        edges(4);
        check_out("scan_d2", 4'b0100, G2);
        edges(4);
        check_out("scan_d3", 4'b1000, G1);
        edges(4);
        check_out("scan_wrap", 4'b0001, G4);   // edge 20, ptr now 1

        // Leading-zero blanking with 0050
        digits_in = 16'h0050;
        blank_lz  = 1'b1;
        load      = 1'b1;
        edges(1);
        load      = 1'b0;
        edges(3);
        check_out("lz_d1", 4'b0010, G5);
        edges(4);
        check_out("lz_d2", 4'b0100, GOFF);
        edges(4);
        check_out("lz_d3", 4'b1000, GOFF);
        edges(4);
        check_out("lz_d0", 4'b0001, G0);       // edge 36, ptr now 1

        // All-zero value: only digit 0 lit
        digits_in = 16'h0000;
        load      = 1'b1;
        edges(1);
        load      = 1'b0;
        edges(3);
        check_out("zero_d1", 4'b0010, GOFF);
        edges(4);
        check_out("zero_d2", 4'b0100, GOFF);
        edges(4);
        check_out("zero_d3", 4'b1000, GOFF);
        edges(4);
        check_out("zero_d0", 4'b0001, G0);     // edge 52, ptr now 1

        // Load coincident with tick edge 56: that slot shows old shadow (0)
        blank_lz = 1'b0;
        edges(3);
        digits_in = 16'h9999;
        load      = 1'b1;
        edges(1);
        load      = 1'b0;
        check_out("coll_old", 4'b0010, G0);
        edges(4);
        check_out("coll_new_d2", 4'b0100, G9);
        edges(4);
        check_out("coll_new_d3", 4'b1000, G9);
        edges(4);
        check_out("coll_new_d0", 4'b0001, G9); // edge 68, ptr now 1

        // Codes 10-15; all non-zero so blanking has no effect
        blank_lz  = 1'b1;
        digits_in = 16'hABCF;
        load      = 1'b1;
        edges(1);
        load      = 1'b0;
        edges(3);
        check_out("hex_d1", 4'b0010, GC);
        edges(4);
        check_out("hex_d2", 4'b0100, GB);
        edges(4);
        check_out("hex_d3", 4'b1000, GA);
        edges(4);
        check_out("hex_d0", 4'b0001, GF);

        // Asynchronous reset mid-scan, asserted between clock edges
        #3;
        reset_a = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, GOFF);
        edges(2);
        check_out("rst_held", 4'b0000, GOFF);

        // Restart: shadow cleared, scan restarts at digit 0
        reset_a  = 1'b1;
        blank_lz = 1'b0;
        edges(3);
        check_out("restart_pre", 4'b0000, GOFF);
        edges(1);
        check_out("restart_d0", 4'b0001, G0);
        edges(4);
        check_out("restart_d1", 4'b0010, G0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Multiplexed, parametrised seven-segment display controller: captures a packed vector of NUM_DIGITS 4-bit codes on a load strobe, then time-multiplexes them onto one shared set of segment lines with a one-hot digit enable, one digit per refresh period. It is the successor to the single-digit combinational decoder and sits at the display end of the multiplier datapath, showing the full product rather than a 3-bit value. It adds a refresh prescaler, shadow register, digit scan counter and optional leading-zero suppression.

## Interface
Parameters:
- NUM_DIGITS, 4, number of scanned digits; legal 1..8.
- REFRESH_DIV, 1024, clk cycles per digit slot; legal ≥ 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_a  input  1  asynchronous, active-low reset.
- digits_in  input  4*NUM_DIGITS  packed codes; bits [4k+3:4k] = digit k, digit 0 least significant.
- load  input  1  capture digits_in into the shadow register this edge.
- blank_lz  input  1  1 = suppress leading zeros.
- seg_a … seg_g  output  1 each  segment drives, active-high (1 = lit), registered.
- digit_en  output  NUM_DIGITS  one-hot digit select, active-high, registered.

## Operation
- Shadow register (4*NUM_DIGITS bits): loaded from digits_in on any edge with load=1; otherwise holds. Display always reads shadow, never digits_in directly.
- Prescaler: counts 0..REFRESH_DIV-1, wraps to 0; tick = (count == REFRESH_DIV-1).
- Scan pointer ptr (0..NUM_DIGITS-1): on tick, outputs are updated for digit ptr, then ptr <= (ptr == NUM_DIGITS-1) ? 0 : ptr+1. With NUM_DIGITS=1, ptr stays 0.
- On tick: digit_en <= one-hot(ptr); seg_a..g <= decode(shadow digit ptr), or all 0 if that digit is blanked.
- Decode (segments lit): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg; 10–15 per Configuration.
- Leading-zero blanking: with blank_lz=1, digit k (k ≥ 1) is blanked iff shadow digits k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked (value 0 shows "0"). Blanked digit keeps digit_en asserted (constant duty cycle), segments all 0. blank_lz sampled at the tick edge.
- Between ticks, outputs hold.

## Timing
- Reset (reset_a=0, asynchronous): prescaler 0, ptr 0, shadow 0, digit_en all 0, seg_a..g all 0. Held while reset_a low.
- After release, first tick at the REFRESH_DIV-th rising edge; outputs show digit 0 from that edge. Digit k then visible on tick k+1; full frame = NUM_DIGITS*REFRESH_DIV cycles.
- load latency: new value displayed from the first tick strictly after the load edge. load and tick on the same edge: that tick uses the old shadow; new shadow used from next tick.
- load held high across many cycles: shadow tracks digits_in every edge.
- Reset mid-scan: all state cleared immediately, outputs go to 0 without waiting for clk; scan restarts at digit 0.
- digit_en is exactly one-hot at all times after first tick; never zero-hot or multi-hot post-reset.

## Configuration
- SEVEN_SEG_HEX_EN defined: codes 10–15 decode as hex: A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
- Not defined: codes 10–15 display dash (seg_g only). Codes 0–9 and blanking unaffected; a code ≥10 counts as non-zero for leading-zero logic.

## Test plan
Bench params NUM_DIGITS=4, REFRESH_DIV=4.
- Reset: reset_a=0 mid-scan → outputs 0 asynchronously; release → first tick at edge 4, digit_en=0001.
- Scan: load digits_in=16'h1234, blank_lz=0 → digit_en 0001,0010,0100,1000,0001 every 4 cycles; segments 4(bcfg),3(abcdg),2(abdeg),1(bc).
- Blanking: load 16'h0050, blank_lz=1 → digit0 "0" abcdef, digit1 "5" acdfg, digits 2,3 segments 0 with digit_en still asserted; load 16'h0000 → only digit0 lit "0".
- Load/tick collision: load 16'h9999 on a tick edge → that slot shows old value, following slots show 9 (abcdfg).
- Hex config: load 16'hABCF → with SEVEN_SEG_HEX_EN F=aefg, C=adef, B=cdefg, A=abcefg; without it all four slots seg_g only.
